adc_scan_ctrl: RTL and testbench
================================

# adc_scan_ctrl

Scan controller for the external 8-channel 12-bit serial ADC (ADC128S022-style protocol) that feeds the gas-sensor analog inputs. It sequences SPI conversion frames over channels 0–4 and handles the one-frame result pipeline of the converter. It publishes a coherent snapshot on `ain_ch0..4_export`-compatible registers and pulses `end_o` once per completed scan. It sits between the ADC pins and the Qsys system's `ain_ch*`/`end_o` inputs.

## Interface

- `CLK_DIV`, default 4: system clocks per SCLK half-period; legal range ≥ 2.
- `SCAN_GAP`, default 1000: idle clocks between the `end_o` pulse and the next scan start.
- `clk_clk` input, 1 bit: system clock; all logic on rising edge.
- `reset_reset_n` input, 1 bit: reset, asynchronous, active-low.
- `en_i` input, 1 bit: scan enable, sampled only in IDLE.
- `adc_cs_n` output, 1 bit: ADC chip select, active-low.
- `adc_sclk` output, 1 bit: ADC serial clock, idles high.
- `adc_din` output, 1 bit: channel address to ADC.
- `adc_dout` input, 1 bit: conversion data from ADC, pre-synchronised externally.
- `ain_ch0`..`ain_ch4` outputs, 12 bits each: latest scan result per channel.
- `end_o` output, 1 bit: one-cycle pulse marking new results.

## Operation

- Reset values: `adc_cs_n`=1, `adc_sclk`=1, `adc_din`=0, `ain_ch0..4`=0, `end_o`=0, FSM=IDLE, frame index=0.
- FSM states:
  - IDLE: if `en_i`=1, go to CS_SETUP; otherwise stay.
  - CS_SETUP: `cs_n`=0, `sclk`=1 for CLK_DIV clocks, then go to SHIFT.
  - SHIFT: 16 SCLK periods, each CLK_DIV clocks low then CLK_DIV clocks high, then go to CS_HOLD.
  - CS_HOLD: `sclk`=1, `cs_n`=0 for CLK_DIV clocks, then go to GAP.
  - GAP: `cs_n`=1 for CLK_DIV clocks. If frame index < 5, increment it and go to CS_SETUP; otherwise go to DONE.
  - DONE: 1 clock, then go to WAIT.
  - WAIT: SCAN_GAP clocks, then go to IDLE.
- A scan is 6 frames, index f = 0..5. Frame f addresses channel f mod 5, giving the address sequence 0,1,2,3,4,0.
- DIN: changes only on SCLK falling edges. During SCLK period n (0..15), DIN = ADD2, ADD1, ADD0 for n = 2, 3, 4 respectively; DIN = 0 for all other periods.
- DOUT: sampled on the system clock that drives SCLK high. Bits in periods n = 4..15 are D11..D0, shifted MSB-first into a 12-bit shift register. Bits in periods 0..3 are ignored.
- At CS_HOLD entry, the shift-register value goes to shadow register f−1 for f ≥ 1. The frame-0 value is discarded, since it belongs to the previous address.
- DONE: all five outputs load from the shadows on the same edge that sets `end_o`=1. `end_o` returns to 0 on the next clock.
- Outputs hold their values between scans; there are no partial updates.
- `en_i` falling mid-scan: the scan completes normally, including DONE and WAIT. The block then stays in IDLE.
- Reset asserted mid-frame: all outputs return to reset values immediately, and shadows are cleared. After release, the first scan restarts at frame 0.

## Timing

- Frame length: (1 + 32 + 1 + 1)·CLK_DIV = 35·CLK_DIV clocks, which is 140 at the defaults.
- SCLK period: 2·CLK_DIV clocks. With a 50 MHz clock and CLK_DIV=4, SCLK = 6.25 MHz, within the ADC's 8 MHz limit.
- Latency from IDLE sampling `en_i`=1 to `end_o`: 1 + 6·35·CLK_DIV clocks = 841 at the defaults.
- First `cs_n` fall is the clock after IDLE samples `en_i`=1.
- Scan period with `en_i` held high: 1 + 210·CLK_DIV + 1 + SCAN_GAP clocks.
- `end_o` pulse width: exactly 1 clock.
- `ain_ch*` are stable for the whole inter-pulse interval.

## Test plan

- ADC model returns 0x111·(ch+1) for the previously addressed channel; hold `en_i`=1. Required: one `end_o` pulse with ain_ch0..4 = 0x111, 0x222, 0x333, 0x444, 0x555, and decoded DIN addresses 0,1,2,3,4,0.
- Defaults with `en_i`=1 from reset release. Required: first `end_o` exactly 841 clocks after IDLE samples `en_i`. Successive pulses are 210·4+2+1000 = 1842 clocks apart; count `cs_n` falls = 6 per scan and SCLK rising edges = 16 per frame.
- Boundary data: model returns 0xFFF on ch2 and 0x000 on all others. Required: ain_ch2 = 0xFFF, others 0x000. Outputs stay unchanged until the next `end_o`, with no intermediate glitch.
- Deassert `en_i` during frame 3. Required: the scan completes with a valid `end_o`, then no further `cs_n` activity for 5000 clocks.
- Assert `reset_reset_n`=0 in SHIFT period 7 of frame 2, after one completed scan. Required: asynchronously `cs_n`=1, `sclk`=1, outputs=0, `end_o`=0. After release with `en_i`=1, a full 6-frame scan produces correct values.
- CLK_DIV=2. Required: SCLK half-period = 2 clocks, DIN changes only while SCLK is low, and results match the first scenario.

Source files
------------

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: scan sequencer for an ADC128S022-style 8-channel 12-bit serial ADC.
// It runs six SPI frames per scan, addressing channels 0,1,2,3,4,0. The converter
// returns the result of the previously addressed channel, so frame f carries
// channel f-1 and frame 0 is discarded. All five results are published together
// with a one-cycle end_o pulse.
module adc_scan_ctrl #(
    parameter int CLK_DIV  = 4,     // system clocks per SCLK half-period, >= 2
    parameter int SCAN_GAP = 1000   // idle clocks after end_o before the next scan
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        en_i,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_din,
    input  logic        adc_dout,
    output logic [11:0] ain_ch0,
    output logic [11:0] ain_ch1,
    output logic [11:0] ain_ch2,
    output logic [11:0] ain_ch3,
    output logic [11:0] ain_ch4,
    output logic        end_o
);

    localparam int CNT_MAX = (CLK_DIV > SCAN_GAP) ? CLK_DIV : SCAN_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(SCAN_GAP - 1);
    localparam logic [2:0]       LAST_FRAME = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT,
        S_CS_HOLD,
        S_GAP,
        S_DONE,
        S_WAIT
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;        // clocks spent in the current phase
    logic             phase, phase_d;    // SHIFT only: 0 = SCLK low half, 1 = high half
    logic [3:0]       period, period_d;  // SCLK period within the frame, 0..15
    logic [2:0]       frame, frame_d;    // frame index within the scan, 0..5
    logic             sample;            // capture adc_dout on this edge
    logic             capture;           // move the shift register into a shadow
    logic [2:0]       chan;              // channel addressed by the upcoming frame
    logic             cs_n_d, sclk_d, din_d;
    logic [11:0]      shift_reg;
    logic [11:0]      shadow [5];

    // Next-state, counter and strobe logic of the frame sequencer.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d  = state;
        cnt_d    = cnt + 1'b1;
        phase_d  = phase;
        period_d = period;
        frame_d  = frame;
        sample   = 1'b0;
        capture  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (en_i) state_d = S_CS_SETUP;
            end
            S_CS_SETUP: begin
                if (cnt == DIV_LAST) begin
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                    phase_d  = 1'b0;
                    period_d = 4'd0;
                end
            end
            S_SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_d = '0;
                    if (!phase) begin
                        // End of the low half: this edge raises SCLK and samples DOUT.
                        phase_d = 1'b1;
                        sample  = (period >= 4'd4);
                    end else if (period == 4'd15) begin
                        state_d = S_CS_HOLD;
                        capture = (frame != 3'd0);
                    end else begin
                        phase_d  = 1'b0;
                        period_d = period + 4'd1;
                    end
                end
            end
            S_CS_HOLD: begin
                if (cnt == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == DIV_LAST) begin
                    cnt_d = '0;
                    if (frame < LAST_FRAME) begin
                        frame_d = frame + 3'd1;
                        state_d = S_CS_SETUP;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                frame_d = 3'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign chan = (frame_d == LAST_FRAME) ? 3'd0 : frame_d;

    // Pin values for the next cycle; DIN only moves together with a falling SCLK.
    always_comb begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        din_d  = 1'b0;
        if (state_d == S_CS_SETUP || state_d == S_CS_HOLD) begin
            cs_n_d = 1'b0;
        end
        if (state_d == S_SHIFT) begin
            cs_n_d = 1'b0;
            sclk_d = phase_d;
            case (period_d)
                4'd2:    din_d = chan[2];
                4'd3:    din_d = chan[1];
                4'd4:    din_d = chan[0];
                default: din_d = 1'b0;
            endcase
        end
    end

    // Sequencer state and counters.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            phase  <= 1'b0;
            period <= 4'd0;
            frame  <= 3'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
            state  <= state_d;
            cnt    <= cnt_d;
            phase  <= phase_d;
            period <= period_d;
            frame  <= frame_d;
        end
    end

    // Registered ADC pins, glitch-free and idle-high on CS and SCLK.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
            adc_din  <= 1'b0;
        end else begin
            adc_cs_n <= cs_n_d;
            adc_sclk <= sclk_d;
            adc_din  <= din_d;
        end
    end

    // DOUT shift register and per-channel shadows filled frame by frame.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            shift_reg <= '0;
            // NOTE: the shadows are a small register file, cleared on reset so an aborted scan leaves nothing stale.
            for (int i = 0; i < 5; i++) shadow[i] <= '0;
        end else begin
            if (sample) shift_reg <= {shift_reg[10:0], adc_dout};
            if (capture) shadow[frame - 3'd1] <= shift_reg;
        end
    end

    // Coherent publish of all five channels with the end-of-scan pulse.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            end_o   <= 1'b0;
            ain_ch0 <= '0;
            ain_ch1 <= '0;
            ain_ch2 <= '0;
            ain_ch3 <= '0;
            ain_ch4 <= '0;
        end else begin
            end_o <= (state == S_DONE);
            if (state == S_DONE) begin
                ain_ch0 <= shadow[0];
                ain_ch1 <= shadow[1];
                ain_ch2 <= shadow[2];
                ain_ch3 <= shadow[3];
                ain_ch4 <= shadow[4];
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Testbench for adc_scan_ctrl: two instances (CLK_DIV=4 and CLK_DIV=2) each
// driven by a behavioural ADC128S022 model; expected results are queued when a
// scan is requested and compared when end_o fires.
`timescale 1ns/1ps
module tb_adc_scan_ctrl;

    localparam int CD0  = 4;
    localparam int GAP0 = 1000;
    localparam int CD1  = 2;
    localparam int GAP1 = 20;

    typedef logic [4:0][11:0] res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, rst1 = 1'b1;
    logic en0 = 1'b0, en1 = 1'b0;
    int   mode0 = 0, mode1 = 0;
    logic done0 = 1'b0, done1 = 1'b0;

    logic [1:0]             cs_n, sclk, din, end_o;
    logic [1:0]             dout = '0;
    logic [1:0][4:0][11:0]  ain;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    always @(posedge clk) cyc++;

    adc_scan_ctrl #(.CLK_DIV(CD0), .SCAN_GAP(GAP0)) u_dut0 (
        .clk_clk(clk), .reset_reset_n(rst0), .en_i(en0),
        .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .adc_din(din[0]), .adc_dout(dout[0]),
        .ain_ch0(ain[0][0]), .ain_ch1(ain[0][1]), .ain_ch2(ain[0][2]),
        .ain_ch3(ain[0][3]), .ain_ch4(ain[0][4]), .end_o(end_o[0])
    );

    adc_scan_ctrl #(.CLK_DIV(CD1), .SCAN_GAP(GAP1)) u_dut1 (
        .clk_clk(clk), .reset_reset_n(rst1), .en_i(en1),
        .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .adc_din(din[1]), .adc_dout(dout[1]),
        .ain_ch0(ain[1][0]), .ain_ch1(ain[1][1]), .ain_ch2(ain[1][2]),
        .ain_ch3(ain[1][3]), .ain_ch4(ain[1][4]), .end_o(end_o[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ADC conversion result for channel ch under a data mode.
    function automatic logic [11:0] adc_word(input int mode, input int ch);
        int v;
        if (mode == 0) v = 'h111 * (ch + 1);
        else           v = (ch == 2) ? 'hFFF : 0;
        return v[11:0];
    endfunction

    function automatic res_t exp_res(input int mode);
        res_t r;
        for (int i = 0; i < 5; i++) r[i] = adc_word(mode, i);
        return r;
    endfunction

    function automatic int mode_of(input int g);
        return (g == 0) ? mode0 : mode1;
    endfunction

    // Scoreboard
    res_t exp_q0[$];
    res_t exp_q1[$];

    function automatic void sb_push(input int g, input res_t r);
        if (g == 0) exp_q0.push_back(r);
        else        exp_q1.push_back(r);
    endfunction

    function automatic int sb_size(input int g);
        return (g == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic res_t sb_pop(input int g);
        if (g == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    function automatic void sb_flush(input int g);
        if (g == 0) exp_q0.delete();
        else        exp_q1.delete();
    endfunction

    // ADC model and protocol monitor state, one slot per instance
    int               n [2]           = '{-1, -1};
    int               frames [2]      = '{0, 0};
    int               total_falls [2] = '{0, 0};
    int               sclk_rises [2]  = '{0, 0};
    int               low_run [2]     = '{0, 0};
    int               half_bad [2]    = '{0, 0};
    int               din_bad [2]     = '{0, 0};
    int               glitches [2]    = '{0, 0};
    int               pulses [2]      = '{0, 0};
    longint           t_start [2]     = '{0, 0};
    longint           t_end [2]       = '{0, 0};
    longint           t_end_prev [2]  = '{0, 0};
    logic [1:0][2:0]  addr            = '0;
    logic [1:0][2:0]  prev_addr       = '0;
    logic [1:0][11:0] word            = '0;
    logic [1:0][17:0] addr_seq        = '0;
    logic [1:0]       p_cs            = '1;
    logic [1:0]       p_sclk          = '1;
    logic [1:0]       p_din           = '0;
    logic [1:0]       p_end           = '0;
    logic [1:0][4:0][11:0] p_ain      = '0;
    logic [1:0][4:0][11:0] last_ain   = '0;

    // Sample pins on the falling clock edge; SCLK and CS only move on rising edges.
    always @(negedge clk) begin
        int   cd;
        logic rst_g;
        res_t e;
        for (int g = 0; g < 2; g++) begin
            cd    = (g == 0) ? CD0 : CD1;
            rst_g = (g == 0) ? rst0 : rst1;
            if (!rst_g) begin
                frames[g]     = 0;
                sclk_rises[g] = 0;
                low_run[g]    = 0;
                glitches[g]   = 0;
                n[g]          = -1;
                dout[g]       = 1'b0;
                addr_seq[g]   = '0;
                last_ain[g]   = '0;
            end else begin
                if (p_cs[g] && !cs_n[g]) begin
                    n[g]          = -1;
                    word[g]       = adc_word(mode_of(g), int'(prev_addr[g]));
                    dout[g]       = 1'b0;
                    sclk_rises[g] = 0;
                    frames[g]++;
                    total_falls[g]++;
                    if (frames[g] == 1) t_start[g] = cyc;
                end
                if (din[g] !== p_din[g] && sclk[g]) din_bad[g]++;
                if (!cs_n[g] && p_sclk[g] && !sclk[g]) begin
                    n[g]++;
                    dout[g] = (n[g] >= 4 && n[g] <= 15) ? word[g][15 - n[g]] : 1'b0;
                end
                if (!cs_n[g] && !p_sclk[g] && sclk[g]) begin
                    sclk_rises[g]++;
                    if (n[g] >= 2 && n[g] <= 4) addr[g][4 - n[g]] = din[g];
                    if (low_run[g] != cd) half_bad[g]++;
                end
                if (sclk[g]) low_run[g] = 0;
                else         low_run[g]++;
                if (!p_cs[g] && cs_n[g]) begin
                    check("sclk_rises_per_frame", sclk_rises[g], 16);
                    addr_seq[g]  = {addr_seq[g][14:0], addr[g]};
                    prev_addr[g] = addr[g];
                end
                if (p_end[g]) check("end_o_width", end_o[g], 0);
                if (end_o[g] && !p_end[g]) begin
                    pulses[g]++;
                    check("latency", cyc - t_start[g], 1 + 210 * cd);
                    check("cs_falls_per_scan", frames[g], 6);
                    check("addr_seq", addr_seq[g], 18'o012340);
                    check("ain_held", p_ain[g], last_ain[g]);
                    check("ain_glitches", glitches[g], 0);
                    check("sb_pending", sb_size(g) > 0, 1);
                    if (sb_size(g) > 0) begin
                        e = sb_pop(g);
                        for (int i = 0; i < 5; i++)
                            check($sformatf("ain_ch%0d_dut%0d", i, g), ain[g][i], e[i]);
                    end
                    last_ain[g]   = ain[g];
                    t_end_prev[g] = t_end[g];
                    t_end[g]      = cyc;
                    frames[g]     = 0;
                    addr_seq[g]   = '0;
                    glitches[g]   = 0;
                end else if (ain[g] != p_ain[g]) begin
                    glitches[g]++;
                end
            end
            p_cs[g]   = cs_n[g];
            p_sclk[g] = sclk[g];
            p_din[g]  = din[g];
            p_end[g]  = end_o[g];
            p_ain[g]  = ain[g];
        end
    end

    task automatic wait_pulses(input int g, input int target, input int budget);
        int k = 0;
        while (pulses[g] < target && k < budget) begin
            tick();
            k++;
        end
        if (pulses[g] < target) check("timeout_end_o", pulses[g], target);
    endtask

    task automatic check_reset_values(input int g, input string tag);
        check({tag, "_cs_n"}, cs_n[g], 1);
        check({tag, "_sclk"}, sclk[g], 1);
        check({tag, "_din"}, din[g], 0);
        check({tag, "_end_o"}, end_o[g], 0);
        check({tag, "_ain"}, ain[g], 0);
    endtask

    // Default-parameter instance: data, timing, boundary, en drop and reset scenarios.
    initial begin : main0
        int     k;
        int     fall_mark;
        #2 rst0 = 1'b0;
        repeat (3) tick();
        check_reset_values(0, "por");

        // Two back-to-back scans with en_i high from reset release.
        sb_push(0, exp_res(0));
        sb_push(0, exp_res(0));
        en0  = 1'b1;
        rst0 = 1'b1;
        wait_pulses(0, 2, 4000);
        en0 = 1'b0;
        check("scan_period", t_end[0] - t_end_prev[0], 210 * CD0 + 2 + GAP0);
        repeat (GAP0 + 10) tick();

        // Full-scale on ch2 only, then normal data; outputs must hold in between.
        mode0 = 1;
        sb_push(0, exp_res(1));
        sb_push(0, exp_res(0));
        en0 = 1'b1;
        wait_pulses(0, 3, 3000);
        mode0 = 0;
        wait_pulses(0, 4, 3000);
        en0 = 1'b0;
        repeat (GAP0 + 10) tick();

        // en_i dropped during frame 3: scan completes, then silence.
        sb_push(0, exp_res(0));
        en0 = 1'b1;
        k = 0;
        while (frames[0] < 4 && k < 3000) begin tick(); k++; end
        if (frames[0] < 4) check("timeout_frame3", frames[0], 4);
        en0 = 1'b0;
        wait_pulses(0, 5, 3000);
        fall_mark = total_falls[0];
        repeat (5000) tick();
        check("idle_cs_falls", total_falls[0] - fall_mark, 0);
        check("idle_cs_n", cs_n[0], 1);

        // Reset in SHIFT period 7 of frame 2, then a clean scan.
        sb_push(0, exp_res(0));
        en0 = 1'b1;
        k = 0;
        while (!(frames[0] == 3 && n[0] == 7) && k < 3000) begin tick(); k++; end
        if (k >= 3000) check("timeout_frame2", frames[0], 3);
        check("pre_reset_ain_ch0", ain[0][0], 12'h111);
        #2 rst0 = 1'b0;
        #1 check_reset_values(0, "async_rst");
        sb_flush(0);
        sb_push(0, exp_res(0));
        repeat (5) tick();
        rst0 = 1'b1;
        wait_pulses(0, 6, 3000);
        en0 = 1'b0;
        repeat (GAP0 + 10) tick();

        check("din_while_sclk_high_dut0", din_bad[0], 0);
        check("sclk_low_half_dut0", half_bad[0], 0);
        check("sb_drained_dut0", sb_size(0), 0);
        done0 = 1'b1;
    end

    // CLK_DIV=2 instance: same data check at the faster SCLK.
    initial begin : main1
        #2 rst1 = 1'b0;
        repeat (3) tick();
        check_reset_values(1, "por_div2");
        sb_push(1, exp_res(0));
        sb_push(1, exp_res(0));
        en1  = 1'b1;
        rst1 = 1'b1;
        wait_pulses(1, 2, 3000);
        en1 = 1'b0;
        check("scan_period_div2", t_end[1] - t_end_prev[1], 210 * CD1 + 2 + GAP1);
        repeat (50) tick();
        check("din_while_sclk_high_dut1", din_bad[1], 0);
        check("sclk_low_half_dut1", half_bad[1], 0);
        check("sb_drained_dut1", sb_size(1), 0);
        done1 = 1'b1;
    end

    initial begin : finish_ctl
        wait (done0 && done1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got done=%b%b expected 11", done1, done0);
        $fatal(1, "watchdog expired");
    end

endmodule
